// File: rtl/slurm32_cpu_decode_hazard.sv
// SLURM32 decode stage: field extraction, a registered decode slot with valid/ready
// on both sides, and a scoreboard of in-flight writes that stalls fetch on RAW hazards.
module slurm32_cpu_decode_hazard #(
    parameter int REG_BITS     = 8,
    parameter int HAZARD_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         in_instr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [REG_BITS-1:0] regA_sel,
    output logic [REG_BITS-1:0] regB_sel,
    output logic                hazard,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_opcode,
    output logic [REG_BITS-1:0] out_dest,
    output logic [REG_BITS-1:0] out_regA,
    output logic [REG_BITS-1:0] out_regB,
    output logic [7:0]          out_imm
);

    localparam logic [3:0] CLS_ALU1 = 4'h0;
    localparam logic [3:0] CLS_ALU3 = 4'h2;
    localparam logic [3:0] CLS_BR   = 4'h4;

    function automatic logic [REG_BITS-1:0] fld(input logic [7:0] b);
        return REG_BITS'(b);
    endfunction

    logic [REG_BITS-1:0] dec_dest, dec_a, dec_b;
    logic                hit_a, hit_b;
    logic                accept, issue;
    logic                slot_vld_d, slot_vld_q;
    logic [7:0]          opcode_q, imm_q;
    logic [REG_BITS-1:0] dest_q, rega_q, regb_q;
    logic                sb_vld_q  [HAZARD_DEPTH];
    logic [REG_BITS-1:0] sb_dest_q [HAZARD_DEPTH];

    always_comb begin
        dec_dest = '0;
        dec_a    = '0;
        dec_b    = '0;
        case (in_instr[31:28])
            CLS_ALU3: begin
                dec_dest = fld(in_instr[23:16]);
                dec_a    = fld(in_instr[15:8]);
                dec_b    = fld(in_instr[7:0]);
            end
            CLS_ALU1: begin
                dec_dest = fld(in_instr[7:0]);
                dec_b    = fld(in_instr[7:0]);
            end
            CLS_BR: begin
                dec_a    = fld(in_instr[15:8]);
            end
            default: ;
        endcase
    end

    // A source conflicts with the instruction sitting in the slot or any write still in flight.
    always_comb begin
        hit_a = slot_vld_q && (dest_q == dec_a);
        hit_b = slot_vld_q && (dest_q == dec_b);
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if (sb_vld_q[i] && (sb_dest_q[i] == dec_a)) hit_a = 1'b1;
            if (sb_vld_q[i] && (sb_dest_q[i] == dec_b)) hit_b = 1'b1;
        end
    end

    assign hazard   = in_valid && (((dec_a != '0) && hit_a) || ((dec_b != '0) && hit_b));
    assign in_ready = !hazard && !flush && (!slot_vld_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = slot_vld_q && out_ready && !flush;

    always_comb begin
        slot_vld_d = slot_vld_q;
        if (flush)       slot_vld_d = 1'b0;
        else if (accept) slot_vld_d = 1'b1;
        else if (issue)  slot_vld_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot_vld_q <= 1'b0;
            opcode_q   <= '0;
            dest_q     <= '0;
            rega_q     <= '0;
            regb_q     <= '0;
            imm_q      <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            if (accept) begin
                opcode_q <= in_instr[31:24];
                dest_q   <= dec_dest;
                rega_q   <= dec_a;
                regb_q   <= dec_b;
                imm_q    <= in_instr[7:0];
            end
        end
    end

    // Scoreboard ages every cycle; r0 writes and flushed instructions never enter it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < HAZARD_DEPTH; i++) begin
                sb_vld_q[i]  <= 1'b0;
                sb_dest_q[i] <= '0;
            end
        end else begin
            sb_vld_q[0]  <= issue && (dest_q != '0);
            sb_dest_q[0] <= dest_q;
            for (int i = 1; i < HAZARD_DEPTH; i++) begin
                sb_vld_q[i]  <= sb_vld_q[i-1];
                sb_dest_q[i] <= sb_dest_q[i-1];
            end
        end
    end

    assign regA_sel   = dec_a;
    assign regB_sel   = dec_b;
    assign out_valid  = slot_vld_q;
    assign out_opcode = opcode_q;
    assign out_dest   = dest_q;
    assign out_regA   = rega_q;
    assign out_regB   = regb_q;
    assign out_imm    = imm_q;

endmodule

// File: tb/tb_slurm32_cpu_decode_hazard.sv
// Directed bench for slurm32_cpu_decode_hazard: decode fields, slot handshake,
// RAW stall timing, back-pressure, flush and reset during a stall.
module tb_slurm32_cpu_decode_hazard;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [7:0]  regA_sel, regB_sel;
    logic        hazard;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode, out_dest, out_regA, out_regB, out_imm;

    int total  = 0;
    int passed = 0;

    slurm32_cpu_decode_hazard #(.REG_BITS(8), .HAZARD_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .regA_sel(regA_sel), .regB_sel(regB_sel), .hazard(hazard),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_dest(out_dest),
        .out_regA(out_regA), .out_regB(out_regB), .out_imm(out_imm)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 4 later.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
        #4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drive(1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b1; flush = 1'b0;
        #12;
        chk("rst_out_valid",  {31'b0, out_valid}, 32'h0);
        chk("rst_out_opcode", {24'b0, out_opcode}, 32'h0);
        chk("rst_out_dest",   {24'b0, out_dest}, 32'h0);
        chk("rst_out_regs",   {16'b0, out_regA, out_regB}, 32'h0);
        chk("rst_out_imm",    {24'b0, out_imm}, 32'h0);
        chk("rst_in_ready",   {31'b0, in_ready}, 32'h1);
        next_cycle();
        RST = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // add r3,r4,r5
        next_cycle();
        drive(1'b1, 32'h21030405, 1'b1, 1'b0);
        chk("add_regA_sel", {24'b0, regA_sel}, 32'h04);
        chk("add_regB_sel", {24'b0, regB_sel}, 32'h05);
        chk("add_hazard",   {31'b0, hazard}, 32'h0);
        chk("add_in_ready", {31'b0, in_ready}, 32'h1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("add_out_valid",  {31'b0, out_valid}, 32'h1);
        chk("add_out_opcode", {24'b0, out_opcode}, 32'h21);
        chk("add_out_dest",   {24'b0, out_dest}, 32'h03);
        chk("add_out_regs",   {16'b0, out_regA, out_regB}, 32'h0405);
        chk("add_out_imm",    {24'b0, out_imm}, 32'h05);
        idle(3);

        // asr r3, then ba [r7,0x10] issued back to back
        next_cycle();
        drive(1'b1, 32'h04000003, 1'b1, 1'b0);
        chk("asr_regA_sel", {24'b0, regA_sel}, 32'h00);
        chk("asr_regB_sel", {24'b0, regB_sel}, 32'h03);
        chk("asr_in_ready", {31'b0, in_ready}, 32'h1);
        next_cycle();
        drive(1'b1, 32'h4e000710, 1'b1, 1'b0);
        chk("asr_out_dest", {24'b0, out_dest}, 32'h03);
        chk("asr_out_regs", {16'b0, out_regA, out_regB}, 32'h0003);
        chk("ba_regA_sel",  {24'b0, regA_sel}, 32'h07);
        chk("ba_regB_sel",  {24'b0, regB_sel}, 32'h00);
        chk("ba_in_ready",  {31'b0, in_ready}, 32'h1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ba_out_valid",  {31'b0, out_valid}, 32'h1);
        chk("ba_out_opcode", {24'b0, out_opcode}, 32'h4e);
        chk("ba_out_dest",   {24'b0, out_dest}, 32'h00);
        chk("ba_out_regA",   {24'b0, out_regA}, 32'h07);
        chk("ba_out_imm",    {24'b0, out_imm}, 32'h10);
        idle(3);

        // RAW: add r3,r4,r5 then add r6,r3,r1 stalls cycles 1-3
        next_cycle();
        drive(1'b1, 32'h21030405, 1'b1, 1'b0);
        chk("raw_c0_in_ready", {31'b0, in_ready}, 32'h1);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            drive(1'b1, 32'h21060301, 1'b1, 1'b0);
            chk($sformatf("raw_c%0d_hazard", c),   {31'b0, hazard}, 32'h1);
            chk($sformatf("raw_c%0d_in_ready", c), {31'b0, in_ready}, 32'h0);
        end
        next_cycle();
        drive(1'b1, 32'h21060301, 1'b1, 1'b0);
        chk("raw_c4_hazard",   {31'b0, hazard}, 32'h0);
        chk("raw_c4_in_ready", {31'b0, in_ready}, 32'h1);
        chk("raw_c4_out_valid", {31'b0, out_valid}, 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("raw_c5_out_valid", {31'b0, out_valid}, 32'h1);
        chk("raw_c5_out_dest",  {24'b0, out_dest}, 32'h06);
        chk("raw_c5_out_regs",  {16'b0, out_regA, out_regB}, 32'h0301);
        idle(3);

        // r0 never hazards; back-pressure holds the slot
        next_cycle();
        drive(1'b1, 32'h21000405, 1'b1, 1'b0);
        chk("r0a_in_ready", {31'b0, in_ready}, 32'h1);
        next_cycle();
        drive(1'b1, 32'h21060000, 1'b1, 1'b0);
        chk("r0b_hazard",   {31'b0, hazard}, 32'h0);
        chk("r0b_in_ready", {31'b0, in_ready}, 32'h1);
        chk("r0b_prev_dest", {24'b0, out_dest}, 32'h00);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive(1'b1, 32'h21070809, 1'b0, 1'b0);
            chk($sformatf("bp%0d_out_valid", c), {31'b0, out_valid}, 32'h1);
            chk($sformatf("bp%0d_out_fields", c), {out_opcode, out_dest, out_regA, out_regB}, 32'h21060000);
            chk($sformatf("bp%0d_hazard", c),    {31'b0, hazard}, 32'h0);
            chk($sformatf("bp%0d_in_ready", c),  {31'b0, in_ready}, 32'h0);
        end
        next_cycle();
        drive(1'b1, 32'h21070809, 1'b1, 1'b0);
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_next_out_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_next_out_dest",  {24'b0, out_dest}, 32'h07);
        idle(3);

        // flush drops the slot without scoreboarding r3
        next_cycle();
        drive(1'b1, 32'h21030405, 1'b1, 1'b0);
        chk("fl_accept_in_ready", {31'b0, in_ready}, 32'h1);
        next_cycle();
        drive(1'b1, 32'h21060301, 1'b1, 1'b1);
        chk("fl_in_ready", {31'b0, in_ready}, 32'h0);
        chk("fl_out_valid_before", {31'b0, out_valid}, 32'h1);
        next_cycle();
        drive(1'b1, 32'h21060301, 1'b1, 1'b0);
        chk("fl_out_valid_after", {31'b0, out_valid}, 32'h0);
        chk("fl_hazard",          {31'b0, hazard}, 32'h0);
        chk("fl_in_ready_after",  {31'b0, in_ready}, 32'h1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("fl_next_out_valid", {31'b0, out_valid}, 32'h1);
        chk("fl_next_out_dest",  {24'b0, out_dest}, 32'h06);
        idle(3);

        // reset in the middle of a hazard stall
        next_cycle();
        drive(1'b1, 32'h21030405, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 32'h21060301, 1'b1, 1'b0);
        chk("rs_hazard_before", {31'b0, hazard}, 32'h1);
        RST = 1'b1;
        #1;
        chk("rs_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rs_hazard",    {31'b0, hazard}, 32'h0);
        chk("rs_out_dest",  {24'b0, out_dest}, 32'h0);
        next_cycle();
        RST = 1'b0;
        drive(1'b1, 32'h21060301, 1'b1, 1'b0);
        chk("rs_rel_hazard",   {31'b0, hazard}, 32'h0);
        chk("rs_rel_in_ready", {31'b0, in_ready}, 32'h1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("rs_rel_out_valid", {31'b0, out_valid}, 32'h1);
        chk("rs_rel_out_dest",  {24'b0, out_dest}, 32'h06);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
